idx_bit_tracker: RTL and testbench
==================================

IDX_BIT_TRACKER -- requirements
Module: idx_bit_tracker

Interface
REQ-001 Parameter IDX_W, default 2, index width; DEPTH = 2**IDX_W tracked bits.
REQ-002 Parameter CLASS_MODE, default 0, index classifier: 0 = idx LSB, 1 = XOR-reduce of idx, 2 = idx MSB; other values behave as 0.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write request.
REQ-006 wr_idx  input  IDX_W  bit index to write.
REQ-007 wr_bit  input  1  value written to vec[wr_idx].
REQ-008 wr_ready  output  1  write accept; combinational = (state==IDLE) && !clr_req && !scan_start.
REQ-009 clr_req  input  1  request sequential clear of all bits.
REQ-010 scan_start  input  1  request scan of set bits.
REQ-011 vec  output  DEPTH  registered tracked bit vector.
REQ-012 pop_cnt  output  IDX_W+1  registered count of ones in vec.
REQ-013 last_class  output  1  registered classifier of the last accepted wr_idx.
REQ-014 busy  output  1  high in CLEAR or SCAN.
REQ-015 scan_valid  output  1  one-cycle pulse per set bit found during SCAN.
REQ-016 scan_idx  output  IDX_W  index reported with scan_valid; holds last value otherwise.
REQ-017 scan_done  output  1  one-cycle pulse on the final SCAN cycle.

Function
REQ-018 FSM states IDLE, CLEAR, SCAN; priority in IDLE: clr_req > scan_start > write.
REQ-019 Write accepted when wr_valid && wr_ready; at that edge vec[wr_idx] <= wr_bit, last_class <= class(wr_idx); one-cycle latency to outputs.
REQ-020 pop_cnt on accepted write: +1 for 0->1, -1 for 1->0, unchanged for same-value write; never wraps (range 0..DEPTH).
REQ-021 IDLE + clr_req: next state CLEAR, internal pointer = 0.
REQ-022 CLEAR: each cycle clear vec[ptr], decrement pop_cnt if that bit was 1, ptr+1; after ptr = DEPTH-1 return to IDLE; exactly DEPTH cycles; pop_cnt = 0 on exit.
REQ-023 IDLE + scan_start (no clr_req): next state SCAN, pointer = 0.
REQ-024 SCAN: each cycle examine vec[ptr]; if 1, scan_valid=1 and scan_idx=ptr (registered, visible next cycle); ptr wraps from DEPTH-1 to 0, state returns to IDLE; scan_done pulses aligned with the last index's report cycle; exactly DEPTH cycles.
REQ-025 vec and pop_cnt are unchanged during SCAN; writes, clr_req and scan_start ignored while busy (no queuing).
REQ-026 last_class unchanged by CLEAR and SCAN.
REQ-027 Empty scan (pop_cnt = 0): no scan_valid pulses, scan_done still pulses.

Reset
REQ-028 reset has priority over all inputs, in any state including mid-CLEAR and mid-SCAN.
REQ-029 Reset values: state IDLE, ptr 0, vec 0, pop_cnt 0, last_class 0, scan_valid 0, scan_idx 0, scan_done 0, busy 0.
REQ-030 First accepted write possible the cycle after reset deasserts.

Verification (IDX_W=2, CLASS_MODE=0 unless noted)
REQ-031 Write idx=0 bit=0, then idx=0 bit=1 -> vec=4'b0001, pop_cnt=1, last_class=0; write idx=3 bit=1 -> vec=4'b1001, pop_cnt=2, last_class=1.
REQ-032 Rewrite idx=3 bit=1 -> pop_cnt stays 2; write idx=3 bit=0 -> vec=4'b0001, pop_cnt=1.
REQ-033 vec=4'b1010, pulse scan_start -> busy 4 cycles, scan_valid with scan_idx=1 then 3, scan_done once, vec unchanged; wr_valid held high meanwhile -> no write accepted.
REQ-034 vec=4'b1111, clr_req and scan_start and wr_valid same cycle -> CLEAR taken, wr_ready=0, after 4 cycles vec=0, pop_cnt=0, state IDLE.
REQ-035 reset asserted mid-SCAN (cycle 2) -> next cycle all outputs at reset values, no scan_done.
REQ-036 CLASS_MODE=1: writes to idx 0,1,2,3 -> last_class sequence 0,1,1,0; CLASS_MODE=2 -> 0,0,1,1.

Source files
------------

// File: rtl/idx_bit_tracker_if.sv
// Bus between a driver and idx_bit_tracker: write port, clear/scan
// commands, tracked vector status and the scan report stream.
interface idx_bit_tracker_if #(
    parameter int IDX_W = 2
);
    localparam int DEPTH = 2 ** IDX_W;

    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_bit;
    logic             wr_ready;
    logic             clr_req;
    logic             scan_start;
    logic [DEPTH-1:0] vec;
    logic [IDX_W:0]   pop_cnt;
    logic             last_class;
    logic             busy;
    logic             scan_valid;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_done;

    modport master (
        output wr_valid, wr_idx, wr_bit, clr_req, scan_start,
        input  wr_ready, vec, pop_cnt, last_class, busy,
        input  scan_valid, scan_idx, scan_done
    );

    modport slave (
        input  wr_valid, wr_idx, wr_bit, clr_req, scan_start,
        output wr_ready, vec, pop_cnt, last_class, busy,
        output scan_valid, scan_idx, scan_done
    );
endinterface

// File: rtl/idx_bit_tracker.sv
// Tracks a 2**IDX_W bit vector with a running popcount; supports single-bit
// writes, a one-bit-per-cycle sequential clear, and a one-bit-per-cycle scan.
module idx_bit_tracker #(
    parameter int IDX_W      = 2,
    parameter int CLASS_MODE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idx_bit_tracker_if.slave     bus
);
    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] PTR_LAST = '1;
    localparam logic [IDX_W-1:0] PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   POP_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   POP_MAX  = (IDX_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0] vec_q, vec_d;
    logic [IDX_W:0]   pop_q, pop_d;
    logic             cls_q, cls_d;
    logic             sv_q, sv_d;
    logic [IDX_W-1:0] sidx_q, sidx_d;
    logic             sdone_q, sdone_d;
    logic             wr_ready;
    logic             wr_fire;

    function automatic logic classify(input logic [IDX_W-1:0] idx);
        if (CLASS_MODE == 1)      return ^idx;
        else if (CLASS_MODE == 2) return idx[IDX_W-1];
        else                      return idx[0];
    endfunction

    assign wr_ready = (state_q == IDLE) && !bus.clr_req && !bus.scan_start;
    assign wr_fire  = bus.wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        vec_d   = vec_q;
        pop_d   = pop_q;
        cls_d   = cls_q;
        sv_d    = 1'b0;
        sidx_d  = sidx_q;
        sdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (bus.scan_start) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end else if (wr_fire) begin
                    vec_d[bus.wr_idx] = bus.wr_bit;
                    cls_d             = classify(bus.wr_idx);
                    // Only a real 0<->1 transition moves the count; saturate as a guard.
                    if (bus.wr_bit && !vec_q[bus.wr_idx] && pop_q != POP_MAX)
                        pop_d = pop_q + POP_ONE;
                    else if (!bus.wr_bit && vec_q[bus.wr_idx] && pop_q != '0)
                        pop_d = pop_q - POP_ONE;
                end
            end
            CLEAR: begin
                vec_d[ptr_q] = 1'b0;
                if (vec_q[ptr_q] && pop_q != '0)
                    pop_d = pop_q - POP_ONE;
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST)
                    state_d = IDLE;
            end
            SCAN: begin
                if (vec_q[ptr_q]) begin
                    sv_d   = 1'b1;
                    sidx_d = ptr_q;
                end
                sdone_d = (ptr_q == PTR_LAST);
                ptr_d   = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            vec_q   <= '0;
            pop_q   <= '0;
            cls_q   <= 1'b0;
            sv_q    <= 1'b0;
            sidx_q  <= '0;
            sdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vec_q   <= vec_d;
            pop_q   <= pop_d;
            cls_q   <= cls_d;
            sv_q    <= sv_d;
            sidx_q  <= sidx_d;
            sdone_q <= sdone_d;
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.vec        = vec_q;
    assign bus.pop_cnt    = pop_q;
    assign bus.last_class = cls_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.scan_valid = sv_q;
    assign bus.scan_idx   = sidx_q;
    assign bus.scan_done  = sdone_q;
endmodule

// File: tb/tb_idx_bit_tracker.sv
// Directed bench: write vector table plus hand sequences for scan, clear,
// empty scan, reset mid-scan and the alternate classifier modes.
module tb_idx_bit_tracker;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    idx_bit_tracker_if #(.IDX_W(2)) if0 ();
    idx_bit_tracker_if #(.IDX_W(2)) if1 ();
    idx_bit_tracker_if #(.IDX_W(2)) if2 ();

    idx_bit_tracker #(.IDX_W(2), .CLASS_MODE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    idx_bit_tracker #(.IDX_W(2), .CLASS_MODE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    idx_bit_tracker #(.IDX_W(2), .CLASS_MODE(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

    typedef struct {
        logic       wv;
        logic [1:0] idx;
        logic       b;
        logic [3:0] vec;
        logic [2:0] pop;
        logic       cls;
    } wvec_t;

    wvec_t tv[11];

    // Per-cycle expectations after each edge, starting with the edge that samples the command
    bit         sc_busy[5] = '{1, 1, 1, 1, 0};
    bit         sc_sv[5]   = '{0, 0, 1, 0, 1};
    int         sc_idx[5]  = '{0, 0, 1, 1, 3};
    bit         sc_done[5] = '{0, 0, 0, 0, 1};
    logic [3:0] cl_vec[5]  = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    int         cl_pop[5]  = '{4, 3, 2, 1, 0};
    bit         m1_cls[4]  = '{0, 1, 1, 0};
    bit         m2_cls[4]  = '{0, 0, 1, 1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic wv, input logic [1:0] idx, input logic b,
                          input logic clr, input logic scan);
        if0.wr_valid   = wv;
        if0.wr_idx     = idx;
        if0.wr_bit     = b;
        if0.clr_req    = clr;
        if0.scan_start = scan;
    endtask

    initial begin
        tv[0]  = '{1'b1, 2'd0, 1'b0, 4'b0000, 3'd0, 1'b0};
        tv[1]  = '{1'b1, 2'd0, 1'b1, 4'b0001, 3'd1, 1'b0};
        tv[2]  = '{1'b1, 2'd3, 1'b1, 4'b1001, 3'd2, 1'b1};
        tv[3]  = '{1'b1, 2'd3, 1'b1, 4'b1001, 3'd2, 1'b1};
        tv[4]  = '{1'b1, 2'd3, 1'b0, 4'b0001, 3'd1, 1'b1};
        tv[5]  = '{1'b1, 2'd2, 1'b1, 4'b0101, 3'd2, 1'b0};
        tv[6]  = '{1'b1, 2'd1, 1'b1, 4'b0111, 3'd3, 1'b1};
        tv[7]  = '{1'b1, 2'd0, 1'b0, 4'b0110, 3'd2, 1'b0};
        tv[8]  = '{1'b1, 2'd2, 1'b0, 4'b0010, 3'd1, 1'b0};
        tv[9]  = '{1'b1, 2'd3, 1'b1, 4'b1010, 3'd2, 1'b1};
        tv[10] = '{1'b0, 2'd0, 1'b1, 4'b1010, 3'd2, 1'b1};

        rst = 1'b1;
        drive0(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        if1.wr_valid = 1'b0; if1.wr_idx = '0; if1.wr_bit = 1'b0; if1.clr_req = 1'b0; if1.scan_start = 1'b0;
        if2.wr_valid = 1'b0; if2.wr_idx = '0; if2.wr_bit = 1'b0; if2.clr_req = 1'b0; if2.scan_start = 1'b0;
        repeat (2) tick();
        chk("rst_vec", 32'(if0.vec), 32'h0);
        chk("rst_pop", 32'(if0.pop_cnt), 32'h0);
        chk("rst_cls", 32'(if0.last_class), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        chk("rst_sv", 32'(if0.scan_valid), 32'h0);
        chk("rst_sidx", 32'(if0.scan_idx), 32'h0);
        chk("rst_sdone", 32'(if0.scan_done), 32'h0);
        rst = 1'b0;

        // Classifier modes 1 and 2
        for (int i = 0; i < 4; i++) begin
            if1.wr_valid = 1'b1; if1.wr_idx = 2'(i); if1.wr_bit = 1'b1;
            if2.wr_valid = 1'b1; if2.wr_idx = 2'(i); if2.wr_bit = 1'b1;
            tick();
            chk($sformatf("m1_cls[%0d]", i), 32'(if1.last_class), 32'(m1_cls[i]));
            chk($sformatf("m2_cls[%0d]", i), 32'(if2.last_class), 32'(m2_cls[i]));
        end
        if1.wr_valid = 1'b0;
        if2.wr_valid = 1'b0;

        // Write table
        for (int i = 0; i < 11; i++) begin
            drive0(tv[i].wv, tv[i].idx, tv[i].b, 1'b0, 1'b0);
            #1;
            chk($sformatf("tv_ready[%0d]", i), 32'(if0.wr_ready), 32'h1);
            tick();
            chk($sformatf("tv_vec[%0d]", i), 32'(if0.vec), 32'(tv[i].vec));
            chk($sformatf("tv_pop[%0d]", i), 32'(if0.pop_cnt), 32'(tv[i].pop));
            chk($sformatf("tv_cls[%0d]", i), 32'(if0.last_class), 32'(tv[i].cls));
        end

        // Scan of 1010 with a write held pending throughout
        drive0(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("scan_ready0", 32'(if0.wr_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) if0.scan_start = 1'b0;
            chk($sformatf("scan_busy[%0d]", c), 32'(if0.busy), 32'(sc_busy[c]));
            chk($sformatf("scan_sv[%0d]", c), 32'(if0.scan_valid), 32'(sc_sv[c]));
            chk($sformatf("scan_idx[%0d]", c), 32'(if0.scan_idx), 32'(sc_idx[c]));
            chk($sformatf("scan_done[%0d]", c), 32'(if0.scan_done), 32'(sc_done[c]));
            chk($sformatf("scan_vec[%0d]", c), 32'(if0.vec), 32'hA);
            chk($sformatf("scan_pop[%0d]", c), 32'(if0.pop_cnt), 32'h2);
            if (c < 4) chk($sformatf("scan_ready[%0d]", c), 32'(if0.wr_ready), 32'h0);
        end
        if0.wr_valid = 1'b0;
        tick();
        chk("scan_sv_end", 32'(if0.scan_valid), 32'h0);
        chk("scan_done_end", 32'(if0.scan_done), 32'h0);

        // Fill to 1111, then clr + scan + write on the same cycle
        drive0(1'b1, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        drive0(1'b1, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        chk("fill_pop", 32'(if0.pop_cnt), 32'h4);
        drive0(1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("clr_ready0", 32'(if0.wr_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin if0.clr_req = 1'b0; if0.scan_start = 1'b0; end
            if (c == 3) if0.wr_valid = 1'b0;
            chk($sformatf("clr_busy[%0d]", c), 32'(if0.busy), 32'(sc_busy[c]));
            chk($sformatf("clr_vec[%0d]", c), 32'(if0.vec), 32'(cl_vec[c]));
            chk($sformatf("clr_pop[%0d]", c), 32'(if0.pop_cnt), 32'(cl_pop[c]));
            chk($sformatf("clr_sv[%0d]", c), 32'(if0.scan_valid | if0.scan_done), 32'h0);
        end
        chk("clr_cls", 32'(if0.last_class), 32'h0);

        // Empty scan: no reports, done still pulses
        drive0(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) if0.scan_start = 1'b0;
            chk($sformatf("escan_busy[%0d]", c), 32'(if0.busy), 32'(sc_busy[c]));
            chk($sformatf("escan_sv[%0d]", c), 32'(if0.scan_valid), 32'h0);
            chk($sformatf("escan_done[%0d]", c), 32'(if0.scan_done), 32'(sc_done[c]));
        end

        // Reset in the middle of a scan
        drive0(1'b1, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        chk("pre_rst_vec", 32'(if0.vec), 32'h2);
        chk("pre_rst_cls", 32'(if0.last_class), 32'h1);
        drive0(1'b0, 2'd0, 1'b0, 1'b0, 1'b1); tick();
        if0.scan_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_sv", 32'(if0.scan_valid), 32'h0);
        chk("mrst_sidx", 32'(if0.scan_idx), 32'h0);
        chk("mrst_done", 32'(if0.scan_done), 32'h0);
        chk("mrst_busy", 32'(if0.busy), 32'h0);
        chk("mrst_vec", 32'(if0.vec), 32'h0);
        chk("mrst_pop", 32'(if0.pop_cnt), 32'h0);
        chk("mrst_cls", 32'(if0.last_class), 32'h0);
        rst = 1'b0;
        drive0(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_rst_ready", 32'(if0.wr_ready), 32'h1);
        tick();
        if0.wr_valid = 1'b0;
        chk("post_rst_vec", 32'(if0.vec), 32'h4);
        chk("post_rst_pop", 32'(if0.pop_cnt), 32'h1);
        chk("post_rst_done0", 32'(if0.scan_done), 32'h0);
        tick();
        chk("post_rst_done1", 32'(if0.scan_done), 32'h0);
        chk("post_rst_busy", 32'(if0.busy), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
